// File: rtl/mar_seq.sv
// Sequencing memory address register: load/clear plus inc/dec/offset-add and a
// shadow register for save/restore/swap. All outputs come straight from flops.
module mar_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int STEP       = 1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclr,
    input  logic                  ena,
    input  logic [2:0]            op,
    input  logic [ADDR_WIDTH-1:0] d,
    input  logic [ADDR_WIDTH-1:0] off,
    output logic [ADDR_WIDTH-1:0] q,
    output logic [ADDR_WIDTH-1:0] shadow_q,
    output logic                  ovf,
    output logic                  ovf_sticky
);

    localparam int AW = ADDR_WIDTH;

    localparam logic [2:0] OP_HOLD    = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_INC     = 3'b010;
    localparam logic [2:0] OP_DEC     = 3'b011;
    localparam logic [2:0] OP_ADD     = 3'b100;
    localparam logic [2:0] OP_SAVE    = 3'b101;
    localparam logic [2:0] OP_RESTORE = 3'b110;
    localparam logic [2:0] OP_SWAP    = 3'b111;

    // Two guard bits: the true sum of an unsigned address and a signed delta spans
    // -2**(AW-1) .. 2**AW-1 + 2**(AW-1), which one extra bit cannot hold.
    localparam logic signed [AW+1:0] STEP_X = (AW+2)'(STEP);

    logic [AW-1:0]          addr_q, addr_d;
    logic [AW-1:0]          shadow_d;
    logic                   ovf_q, ovf_d;
    logic                   sticky_q, sticky_d;
    logic signed [AW+1:0]   delta;
    logic signed [AW+1:0]   sum;
    logic                   fault;
    logic [AW-1:0]          arith_res;

    always_comb begin
        case (op)
            OP_INC:  delta = STEP_X;
            OP_DEC:  delta = -STEP_X;
            default: delta = $signed({{2{off[AW-1]}}, off});
        endcase
        sum   = $signed({2'b00, addr_q}) + delta;
        // Negative sets the top bit; above all-ones sets bit AW while staying positive.
        fault = sum[AW+1] | sum[AW];
    end

    generate
        if (SATURATE != 0) begin : g_sat
            assign arith_res = sum[AW+1] ? '0 : (sum[AW] ? '1 : sum[AW-1:0]);
        end else begin : g_wrap
            assign arith_res = sum[AW-1:0];
        end
    endgenerate

    always_comb begin
        addr_d   = addr_q;
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        if (sclr) begin
            addr_d   = '0;
            shadow_d = '0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
        end else if (ena) begin
            ovf_d = 1'b0;
            case (op)
                OP_LOAD: addr_d = d;
                OP_INC, OP_DEC, OP_ADD: begin
                    addr_d   = arith_res;
                    ovf_d    = fault;
                    sticky_d = sticky_q | fault;
                end
                OP_SAVE:    shadow_d = addr_q;
                OP_RESTORE: addr_d   = shadow_q;
                OP_SWAP: begin
                    addr_d   = shadow_q;
                    shadow_d = addr_q;
                end
                default: ; // OP_HOLD
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign q          = addr_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule
